line_buffer_ctrl: RTL and testbench
===================================

// Module: line_buffer_ctrl
// PURPOSE
// - Sequences two row_ram instances into a 3-row line buffer for the 3x3 Sobel stage.
// - Takes a raster pixel stream and emits a column of three vertically aligned pixels per input pixel.
// - The three pixels are rows y-2, y-1 and y, plus position and border flags.
// - Sits between the pixel input/grayscale stage and the 3x3 window/Sobel kernel.
// PARAMETERS
// - WIDTH      640  pixels per line; row_ram DEPTH
// - HEIGHT     480  lines per frame
// - ADDR_BITS  10   column counter / RAM address width; must satisfy 2**ADDR_BITS >= WIDTH
// - ROW_BITS   9    row counter width; must satisfy 2**ROW_BITS >= HEIGHT
// PORTS
// - clk         in   1          system clock, all logic on rising edge
// - rst         in   1          asynchronous, active-high reset
// - sof         in   1          start of frame, qualified by pix_valid; marks pixel (0,0)
// - pix_valid   in   1          input pixel strobe; gaps allowed, no backpressure
// - pix_data    in   8          input pixel
// - tap_top     out  8          pixel at (row-2, col)
// - tap_mid     out  8          pixel at (row-1, col)
// - tap_bot     out  8          pixel at (row, col), the delayed input
// - out_valid   out  1          taps/position valid this cycle
// - out_col     out  ADDR_BITS  column of current taps
// - out_row     out  ROW_BITS   row of current taps
// - win_valid   out  1          out_valid and out_row>=2, i.e. all three taps are real data
// - first_col   out  1          out_col==0
// - last_col    out  1          out_col==WIDTH-1
// - frame_done  out  1          one-cycle pulse, coincident with out_valid of pixel (HEIGHT-1,WIDTH-1)
// BEHAVIOUR
// - Reset: state=IDLE; col, row and sel are 0; all outputs are 0. RAM contents are not cleared.
// - FSM IDLE -> ACTIVE: on pix_valid&sof. That pixel is accepted as (0,0).
//   - pix_valid without sof in IDLE is dropped; no RAM write, no out_valid.
// - FSM ACTIVE: each pix_valid is accepted at (row,col).
//   - col increments and wraps at WIDTH-1 to 0.
//   - On that wrap, row increments and sel toggles.
//   - The accepted pixel at (HEIGHT-1,WIDTH-1) returns the FSM to IDLE with col/row/sel cleared.
// - sof in ACTIVE (pix_valid&sof): restarts the frame. The pixel is (0,0) and sel=0.
//   - Old rows stay in RAM; win_valid stays low until row 2, so stale data is never flagged valid.
// - RAM use: ram[sel] holds the oldest row (y-2), ram[~sel] holds y-1.
//   - On an accepted pixel, both raddr=col.
//   - ram[sel] gets we=1, waddr=col, wdata=pix_data; ram[~sel] gets we=0.
//   - row_ram is read-before-write, so rdata returns the old y-2 value the next cycle.
// - Latency: exactly 1 cycle from accepted pixel to out_valid. This is a single registered stage.
//   - Stage captures pix_data, col, row, sel and the accept bit.
//   - tap_bot = pix_d; tap_top = rdata[sel_d]; tap_mid = rdata[~sel_d].
//   - Taps and position hold their last values when out_valid=0.
// - Rows 0 and 1: out_valid=1 and win_valid=0; tap_top and tap_mid are don't-care.
// - Gaps in pix_valid: counters hold, RAMs are not written, out_valid=0 the next cycle.
// - Reset mid-frame clears per the reset line above. The next frame requires sof.
// STRUCTURE
// - edge_pkg: state_t {IDLE, ACTIVE}, default WIDTH/HEIGHT constants, pixel_t (logic [7:0]).
// - Sub-module: two row_ram instances (u_row0, u_row1), DEPTH=WIDTH, ADDR_BITS passed through.
// - Rest of the block is the counter/FSM and the output register in this file.
// TESTING (bench uses WIDTH=4, HEIGHT=3)
// - Reset: assert rst mid-stream -> all outputs 0 in the same cycle; pixels without sof are then ignored.
// - Frame fill: sof at row0=0..3, row1=10..13, row2=20..23 with pix_valid held high.
//   - Row 2 col 1 -> top=1, mid=11, bot=21, win_valid=1, first_col=0.
//   - Row 0/1 outputs have win_valid=0.
// - Borders and done: pixel 23 -> last_col=1, frame_done=1 for one cycle; next cycle FSM=IDLE.
// - Gaps: pix_valid toggled 1/0 through the frame -> identical tap values as the fill case.
//   - out_valid exactly 1 cycle after each accepted pixel.
// - Restart: sof at row1 col2, then a new frame 100..123.
//   - row2 col0 -> top=100, mid=110, bot=120; no win_valid before new row 2.
// - Second frame back-to-back (sof the cycle after frame_done) with values +50.
//   - row2 col3 -> top=53, mid=63, bot=73; sel restarted so there is no row swap.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types and default geometry for the edge-detection pipeline.
//   pixel_t   : 8-bit grayscale pixel
//   state_t   : line buffer sequencer states
//   DEF_*     : default frame geometry and counter widths
package edge_pkg;

    localparam int unsigned PIX_BITS      = 8;
    localparam int unsigned DEF_WIDTH     = 640;
    localparam int unsigned DEF_HEIGHT    = 480;
    localparam int unsigned DEF_ADDR_BITS = 10;
    localparam int unsigned DEF_ROW_BITS  = 9;

    typedef logic [PIX_BITS-1:0] pixel_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/row_ram.sv
// Single-row pixel store, one write port and one registered read port.
// A read and a write to the same address in one cycle return the old data.
//   clk, rst     : clock, async active-high reset (read register only)
//   re, raddr    : read enable / address; rdata holds when re=0
//   we, waddr    : write enable / address
//   wdata, rdata : write data / registered read data
module row_ram
    import edge_pkg::*;
#(
    parameter int unsigned DEPTH     = DEF_WIDTH,
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    pixel_t mem [DEPTH];

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register; NBA ordering gives read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// 3-row line buffer sequencer for the 3x3 Sobel stage. Each accepted raster
// pixel yields, one cycle later, the vertically aligned column (y-2, y-1, y)
// with its position and border flags.
//   clk, rst              : clock, async active-high reset
//   sof, pix_valid        : frame start (qualified by pix_valid), pixel strobe
//   pix_data              : input pixel
//   tap_top/mid/bot       : pixels at rows y-2, y-1, y of column out_col
//   out_valid             : taps/position valid
//   out_col, out_row      : position of the current taps
//   win_valid             : out_valid with out_row >= 2
//   first_col, last_col   : column border flags
//   frame_done            : pulse with the last pixel of the frame
module line_buffer_ctrl
    import edge_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned HEIGHT    = DEF_HEIGHT,
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
    parameter int unsigned ROW_BITS  = DEF_ROW_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sof,
    input  logic                 pix_valid,
    input  logic [7:0]           pix_data,
    output logic [7:0]           tap_top,
    output logic [7:0]           tap_mid,
    output logic [7:0]           tap_bot,
    output logic                 out_valid,
    output logic [ADDR_BITS-1:0] out_col,
    output logic [ROW_BITS-1:0]  out_row,
    output logic                 win_valid,
    output logic                 first_col,
    output logic                 last_col,
    output logic                 frame_done
);

    localparam logic [ADDR_BITS-1:0] COL_LAST = ADDR_BITS'(WIDTH - 1);
    localparam logic [ROW_BITS-1:0]  ROW_LAST = ROW_BITS'(HEIGHT - 1);
    localparam logic [ROW_BITS-1:0]  ROW_WIN  = ROW_BITS'(2);

    state_t               state;
    logic [ADDR_BITS-1:0] col;
    logic [ROW_BITS-1:0]  row;
    logic                 sel;
    logic                 sel_d;

    logic                 accept;
    logic [ADDR_BITS-1:0] acc_col;
    logic [ROW_BITS-1:0]  acc_row;
    logic                 acc_sel;
    logic [7:0]           rdata0;
    logic [7:0]           rdata1;

    // Position of the pixel being accepted; sof forces (0,0) with sel=0.
    always_comb begin
        accept  = pix_valid & (sof | (state == ACTIVE));
        acc_col = col;
        acc_row = row;
        acc_sel = sel;
        if (sof) begin
            acc_col = '0;
            acc_row = '0;
            acc_sel = 1'b0;
        end
    end

    // Raster counters and sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            sel   <= 1'b0;
        end else if (accept) begin
            if (acc_col == COL_LAST) begin
                col <= '0;
                if (acc_row == ROW_LAST) begin
                    state <= IDLE;
                    row   <= '0;
                    sel   <= 1'b0;
                end else begin
                    state <= ACTIVE;
                    row   <= acc_row + ROW_BITS'(1);
                    sel   <= ~acc_sel;
                end
            end else begin
                state <= ACTIVE;
                col   <= acc_col + ADDR_BITS'(1);
                row   <= acc_row;
                sel   <= acc_sel;
            end
        end
    end

    // ram[sel] holds row y-2 and is overwritten by row y as it is read.
    row_ram #(.DEPTH(WIDTH), .ADDR_BITS(ADDR_BITS)) u_row0 (
        .clk   (clk),
        .rst   (rst),
        .re    (accept),
        .raddr (acc_col),
        .we    (accept & ~acc_sel),
        .waddr (acc_col),
        .wdata (pix_data),
        .rdata (rdata0)
    );

    row_ram #(.DEPTH(WIDTH), .ADDR_BITS(ADDR_BITS)) u_row1 (
        .clk   (clk),
        .rst   (rst),
        .re    (accept),
        .raddr (acc_col),
        .we    (accept & acc_sel),
        .waddr (acc_col),
        .wdata (pix_data),
        .rdata (rdata1)
    );

    // Output stage, aligned with the RAM read register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            tap_bot    <= '0;
            out_col    <= '0;
            out_row    <= '0;
            sel_d      <= 1'b0;
            first_col  <= 1'b0;
            last_col   <= 1'b0;
        end else begin
            out_valid  <= accept;
            win_valid  <= accept & (acc_row >= ROW_WIN);
            frame_done <= accept & (acc_row == ROW_LAST) & (acc_col == COL_LAST);
            if (accept) begin
                tap_bot   <= pix_data;
                out_col   <= acc_col;
                out_row   <= acc_row;
                sel_d     <= acc_sel;
                first_col <= (acc_col == '0);
                last_col  <= (acc_col == COL_LAST);
            end
        end
    end

    // Read registers only update on accept, so taps hold through gaps.
    assign tap_top = sel_d ? rdata1 : rdata0;
    assign tap_mid = sel_d ? rdata0 : rdata1;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl on a 4x3 frame.
module tb_line_buffer_ctrl;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned HEIGHT    = 3;
    localparam int unsigned ADDR_BITS = 2;
    localparam int unsigned ROW_BITS  = 2;

    logic                 clk;
    logic                 rst;
    logic                 sof;
    logic                 pix_valid;
    logic [7:0]           pix_data;
    logic [7:0]           tap_top;
    logic [7:0]           tap_mid;
    logic [7:0]           tap_bot;
    logic                 out_valid;
    logic [ADDR_BITS-1:0] out_col;
    logic [ROW_BITS-1:0]  out_row;
    logic                 win_valid;
    logic                 first_col;
    logic                 last_col;
    logic                 frame_done;

    int n_vec;
    int n_err;

    line_buffer_ctrl #(
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .ADDR_BITS (ADDR_BITS),
        .ROW_BITS  (ROW_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sof        (sof),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .tap_top    (tap_top),
        .tap_mid    (tap_mid),
        .tap_bot    (tap_bot),
        .out_valid  (out_valid),
        .out_col    (out_col),
        .out_row    (out_row),
        .win_valid  (win_valid),
        .first_col  (first_col),
        .last_col   (last_col),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock with a pixel on the input; outputs sampled 1 time unit after the edge.
    task automatic px(input logic s, input logic [7:0] d);
        sof       = s;
        pix_valid = 1'b1;
        pix_data  = d;
        @(posedge clk);
        #1;
        sof       = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic gap();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_bot"},   32'(tap_bot),   32'd0);
        chk({tag, "_top"},   32'(tap_top),   32'd0);
        chk({tag, "_mid"},   32'(tap_mid),   32'd0);
        chk({tag, "_col"},   32'(out_col),   32'd0);
        chk({tag, "_row"},   32'(out_row),   32'd0);
        chk({tag, "_flags"}, 32'({win_valid, first_col, last_col, frame_done}), 32'd0);
    endtask

    // Full frame, value base + 10*row + col; optional idle cycle after every pixel.
    task automatic feed_frame(input logic [7:0] base, input bit gaps);
        logic [7:0] d;
        for (int r = 0; r < int'(HEIGHT); r++) begin
            for (int c = 0; c < int'(WIDTH); c++) begin
                d = base + 8'(r * 10 + c);
                px(r == 0 && c == 0, d);
                chk("valid", 32'(out_valid),  32'd1);
                chk("col",   32'(out_col),    32'(c));
                chk("row",   32'(out_row),    32'(r));
                chk("bot",   32'(tap_bot),    32'(d));
                chk("win",   32'(win_valid),  32'(r >= 2));
                chk("first", 32'(first_col),  32'(c == 0));
                chk("last",  32'(last_col),   32'(c == 3));
                chk("done",  32'(frame_done), 32'(r == 2 && c == 3));
                if (r == 2) begin
                    chk("top", 32'(tap_top), 32'(base + 8'(c)));
                    chk("mid", 32'(tap_mid), 32'(base + 8'(10 + c)));
                end
                if (gaps) begin
                    gap();
                    chk("gap_valid", 32'(out_valid), 32'd0);
                    chk("gap_win",   32'(win_valid), 32'd0);
                    chk("gap_bot",   32'(tap_bot),   32'(d));
                    chk("gap_col",   32'(out_col),   32'(c));
                    chk("gap_done",  32'(frame_done), 32'd0);
                end
            end
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        sof       = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst_init");
        rst = 1'b0;

        // Pixels without sof in IDLE are dropped.
        px(1'b0, 8'd77);
        chk("idle_drop", 32'(out_valid), 32'd0);

        // Reset asserted mid-frame clears outputs immediately.
        px(1'b1, 8'd5);
        px(1'b0, 8'd6);
        chk("pre_rst_bot", 32'(tap_bot), 32'd6);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        px(1'b0, 8'd55);
        chk("post_rst_drop", 32'(out_valid), 32'd0);
        chk("post_rst_bot",  32'(tap_bot),   32'd0);

        // Frame fill, then a back-to-back frame offset by 50.
        feed_frame(8'd0, 1'b0);
        feed_frame(8'd50, 1'b0);
        gap();
        chk("done_pulse", 32'(frame_done), 32'd0);
        chk("after_done", 32'(out_valid),  32'd0);
        px(1'b0, 8'd99);
        chk("idle_after_frame", 32'(out_valid), 32'd0);

        // Same frame with pix_valid toggling.
        feed_frame(8'd0, 1'b1);

        // Abandoned frame restarted by sof at row 1 col 2.
        px(1'b1, 8'd0);
        px(1'b0, 8'd1);
        px(1'b0, 8'd2);
        px(1'b0, 8'd3);
        px(1'b0, 8'd10);
        chk("rs_row1_win", 32'(win_valid), 32'd0);
        px(1'b0, 8'd11);
        chk("rs_row1_row", 32'(out_row), 32'd1);
        feed_frame(8'd100, 1'b0);

        gap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
